// File: rtl/datapath_pkg.sv
// Shared opcode encodings for the mini CPU ALU datapath and its decoder.
package datapath_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLT   = 4'd5;
  localparam logic [3:0] OP_SLL   = 4'd6;
  localparam logic [3:0] OP_SRL   = 4'd7;
  localparam logic [3:0] OP_SRA   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_NOR   = 4'd10;
  localparam logic [3:0] OP_PASSA = 4'd11;
  localparam logic [3:0] OP_PASSB = 4'd12;
  localparam logic [3:0] OP_INC   = 4'd13;
  localparam logic [3:0] OP_DEC   = 4'd14;
  localparam logic [3:0] OP_NOP   = 4'd15;

endpackage

// File: rtl/datapath_if.sv
// Operand/opcode inputs and registered result/flag outputs of the ALU datapath.
interface datapath_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       Op;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             Neg;
  logic             Carry;
  logic             Overflow;

  modport master (
    output A, B, Op,
    input  Result, Zero, Neg, Carry, Overflow
  );

  modport slave (
    input  A, B, Op,
    output Result, Zero, Neg, Carry, Overflow
  );
endinterface

// File: rtl/alu_comb.sv
// Combinational ALU: result plus Zero/Neg/Carry/Overflow for one opcode.
module alu_comb
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             overflow
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             is_add;
  logic             is_sub;

  // INC/DEC reuse the ADD/SUB adders with a constant-one operand.
  assign sh     = b[SHW-1:0];
  assign is_add = (op == OP_ADD) || (op == OP_INC);
  assign is_sub = (op == OP_SUB) || (op == OP_DEC);
  assign opnd   = ((op == OP_INC) || (op == OP_DEC)) ? WIDTH'(1) : b;
  assign sum    = {1'b0, a} + {1'b0, opnd};
  assign diff   = {1'b0, a} - {1'b0, opnd};

  always_comb begin
    result = '0;
    unique case (op)
      OP_ADD, OP_INC: result = sum[WIDTH-1:0];
      OP_SUB, OP_DEC: result = diff[WIDTH-1:0];
      OP_AND:         result = a & b;
      OP_OR:          result = a | b;
      OP_XOR:         result = a ^ b;
      OP_SLT:         result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:         result = a << sh;
      OP_SRL:         result = a >> sh;
      OP_SRA:         result = WIDTH'($signed(a) >>> sh);
      OP_SLTU:        result = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_NOR:         result = ~(a | b);
      OP_PASSA:       result = a;
      OP_PASSB:       result = b;
      default:        result = '0;
    endcase
  end

  always_comb begin
    carry    = 1'b0;
    overflow = 1'b0;
    if (is_add) begin
      carry    = sum[WIDTH];
      overflow = (a[WIDTH-1] == opnd[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end else if (is_sub) begin
      carry    = diff[WIDTH];
      overflow = (a[WIDTH-1] != opnd[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    end
  end

  assign zero = (result == '0);
  assign neg  = result[WIDTH-1];

endmodule

// File: rtl/datapath_core.sv
// Single-stage ALU datapath: alu_comb followed by the result/flag register.
module datapath_core
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic       clk,
  input logic       rst_n,
  datapath_if.slave bus
);

  logic [WIDTH-1:0] res_d;
  logic             zero_d;
  logic             neg_d;
  logic             carry_d;
  logic             ovf_d;

  alu_comb #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a        (bus.A),
    .b        (bus.B),
    .op       (bus.Op),
    .result   (res_d),
    .zero     (zero_d),
    .neg      (neg_d),
    .carry    (carry_d),
    .overflow (ovf_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.Result   <= '0;
      bus.Zero     <= 1'b1;
      bus.Neg      <= 1'b0;
      bus.Carry    <= 1'b0;
      bus.Overflow <= 1'b0;
    end else begin
      bus.Result   <= res_d;
      bus.Zero     <= zero_d;
      bus.Neg      <= neg_d;
      bus.Carry    <= carry_d;
      bus.Overflow <= ovf_d;
    end
  end

endmodule

// File: tb/tb_datapath_core.sv
// Directed-vector bench for datapath_core at WIDTH=8; flags packed as {Z,N,C,V}.
module tb_datapath_core;
  import datapath_pkg::*;

  logic clk;
  logic rst_n;
  int unsigned total;
  int unsigned bad;

  datapath_if #(.WIDTH(8)) bus ();

  datapath_core #(
    .WIDTH(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got res=%h znc v=%b, expected res=%h zncv=%b",
               tag, got[11:4], got[3:0], exp[11:4], exp[3:0]);
    end
  endtask

  function automatic logic [11:0] observed();
    return {bus.Result, bus.Zero, bus.Neg, bus.Carry, bus.Overflow};
  endfunction

  task automatic step(input string tag, input logic [3:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] res, input logic [3:0] zncv);
    @(negedge clk);
    bus.Op = op;
    bus.A  = a;
    bus.B  = b;
    @(posedge clk);
    #1;
    chk(tag, observed(), {res, zncv});
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    bus.A  = '0;
    bus.B  = '0;
    bus.Op = OP_ADD;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_init", observed(), {8'h00, 4'b1000});
    @(negedge clk);
    rst_n = 1'b1;

    step("add_05_03",   OP_ADD,   8'h05, 8'h03, 8'h08, 4'b0000);
    step("sub_0c_07",   OP_SUB,   8'h0C, 8'h07, 8'h05, 4'b0000);
    step("sub_03_05",   OP_SUB,   8'h03, 8'h05, 8'hFE, 4'b0110);
    step("and_f0_0f",   OP_AND,   8'hF0, 8'h0F, 8'h00, 4'b1000);
    step("or_aa_55",    OP_OR,    8'hAA, 8'h55, 8'hFF, 4'b0100);
    step("xor_c3_3c",   OP_XOR,   8'hC3, 8'h3C, 8'hFF, 4'b0100);
    step("slt_02_05",   OP_SLT,   8'h02, 8'h05, 8'h01, 4'b0000);
    step("slt_80_01",   OP_SLT,   8'h80, 8'h01, 8'h01, 4'b0000);
    step("sltu_80_01",  OP_SLTU,  8'h80, 8'h01, 8'h00, 4'b1000);
    step("sll_0f_2",    OP_SLL,   8'h0F, 8'h02, 8'h3C, 4'b0000);
    step("srl_f0_3",    OP_SRL,   8'hF0, 8'h03, 8'h1E, 4'b0000);
    step("sra_f0_3",    OP_SRA,   8'hF0, 8'h03, 8'hFE, 4'b0100);
    step("sll_b0a",     OP_SLL,   8'h0F, 8'h0A, 8'h3C, 4'b0000);
    step("sra_70_4",    OP_SRA,   8'h70, 8'h04, 8'h07, 4'b0000);
    step("srl_sh0",     OP_SRL,   8'h81, 8'h08, 8'h81, 4'b0100);
    step("add_7f_01",   OP_ADD,   8'h7F, 8'h01, 8'h80, 4'b0101);
    step("add_ff_01",   OP_ADD,   8'hFF, 8'h01, 8'h00, 4'b1010);
    step("sub_80_01",   OP_SUB,   8'h80, 8'h01, 8'h7F, 4'b0001);
    step("nor_0f_f0",   OP_NOR,   8'h0F, 8'hF0, 8'h00, 4'b1000);
    step("passa_85",    OP_PASSA, 8'h85, 8'h11, 8'h85, 4'b0100);
    step("passb_00",    OP_PASSB, 8'h85, 8'h00, 8'h00, 4'b1000);
    step("inc_ff",      OP_INC,   8'hFF, 8'h55, 8'h00, 4'b1010);
    step("inc_7f",      OP_INC,   8'h7F, 8'h00, 8'h80, 4'b0101);
    step("dec_00",      OP_DEC,   8'h00, 8'h33, 8'hFF, 4'b0110);
    step("dec_80",      OP_DEC,   8'h80, 8'h00, 8'h7F, 4'b0001);
    step("nop_ff_ff",   OP_NOP,   8'hFF, 8'hFF, 8'h00, 4'b1000);
    step("add_pre_rst", OP_ADD,   8'h90, 8'h90, 8'h20, 4'b0011);

    // Mid-cycle reset must clear outputs without waiting for a clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_async", observed(), {8'h00, 4'b1000});
    bus.Op = OP_ADD;
    bus.A  = 8'h05;
    bus.B  = 8'h03;
    @(posedge clk);
    #1;
    chk("reset_hold", observed(), {8'h00, 4'b1000});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_after_rst", observed(), {8'h08, 4'b0000});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
